// File: rtl/loteria_escalonador.sv
// Shared-checker scheduler: round-robin grant among four terminals, then drives the
// single checker through five digit inserts, a finish strobe and a bounded result wait.
module loteria_escalonador #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [79:0] ticket,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [1:0]  prize,
    output logic        timeout_err,
    output logic        bad_ticket,
    output logic [3:0]  chk_num,
    output logic        chk_insert,
    output logic        chk_finish,
    input  logic        chk_valid,
    input  logic [1:0]  chk_prize,
    output logic        busy,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND   = 3'd1,
        S_FINISH = 3'd2,
        S_WAIT   = 3'd3,
        S_REPLY  = 3'd4
    } state_e;

    state_e             state_q;
    logic [1:0]         ptr_q;
    logic [1:0]         gidx_q;
    logic [19:0]        tkt_q;
    logic [2:0]         d_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [3:0]         gnt_q;
    logic [3:0]         done_q;
    logic [1:0]         prize_q;
    logic               timeout_err_q;
    logic               bad_ticket_q;
    logic               bad_q;
    logic               arm_q;
    logic [3:0]         chk_num_q;
    logic               chk_insert_q;
    logic               chk_finish_q;
    logic               busy_q;

    logic [1:0]         sel;
    logic [1:0]         idx;
    logic               found;
    logic [19:0]        tkt_sel;
    logic               tkt_ok;

    function automatic logic [3:0] digit_at(input logic [19:0] t, input logic [2:0] i);
        case (i)
            3'd0:    digit_at = t[19:16];
            3'd1:    digit_at = t[15:12];
            3'd2:    digit_at = t[11:8];
            3'd3:    digit_at = t[7:4];
            default: digit_at = t[3:0];
        endcase
    endfunction

    // First requester at or after ptr, wrapping 3 -> 0
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        tkt_sel = '0;
        case (sel)
            2'd0:    tkt_sel = ticket[19:0];
            2'd1:    tkt_sel = ticket[39:20];
            2'd2:    tkt_sel = ticket[59:40];
            default: tkt_sel = ticket[79:60];
        endcase
        tkt_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (tkt_sel[4*i +: 4] > 4'd9) tkt_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            gidx_q        <= '0;
            tkt_q         <= '0;
            d_q           <= '0;
            wcnt_q        <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            prize_q       <= '0;
            timeout_err_q <= 1'b0;
            bad_ticket_q  <= 1'b0;
            bad_q         <= 1'b0;
            arm_q         <= 1'b0;
            chk_num_q     <= '0;
            chk_insert_q  <= 1'b0;
            chk_finish_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            done_q        <= '0;
            prize_q       <= '0;
            timeout_err_q <= 1'b0;
            bad_ticket_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        gnt_q  <= 4'(1) << sel;
                        gidx_q <= sel;
                        tkt_q  <= tkt_sel;
                        d_q    <= '0;
                        busy_q <= 1'b1;
                        if (tkt_ok) begin
                            chk_insert_q <= 1'b1;
                            chk_num_q    <= tkt_sel[19:16];
                            state_q      <= S_SEND;
                        end else begin
                            // Bad ticket skips the checker; REPLY holds one extra cycle before done
                            bad_q   <= 1'b1;
                            arm_q   <= 1'b1;
                            state_q <= S_REPLY;
                        end
                    end
                end
                S_SEND: begin
                    if (d_q == 3'd4) begin
                        chk_insert_q <= 1'b0;
                        chk_num_q    <= '0;
                        chk_finish_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end else begin
                        d_q       <= d_q + 3'd1;
                        chk_num_q <= digit_at(tkt_q, d_q + 3'd1);
                    end
                end
                S_FINISH: begin
                    chk_finish_q <= 1'b0;
                    wcnt_q       <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (chk_valid) begin
                        prize_q <= chk_prize;
                        done_q  <= gnt_q;
                        state_q <= S_REPLY;
                    end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        done_q        <= gnt_q;
                        state_q       <= S_REPLY;
                    end else begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                end
                S_REPLY: begin
                    if (arm_q) begin
                        arm_q        <= 1'b0;
                        done_q       <= gnt_q;
                        bad_ticket_q <= bad_q;
                    end else begin
                        gnt_q   <= '0;
                        ptr_q   <= gidx_q + 2'd1;
                        bad_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign prize       = prize_q;
    assign timeout_err = timeout_err_q;
    assign bad_ticket  = bad_ticket_q;
    assign chk_num     = chk_num_q;
    assign chk_insert  = chk_insert_q;
    assign chk_finish  = chk_finish_q;
    assign busy        = busy_q;
    assign state       = state_q;

endmodule

// File: tb/tb_loteria_escalonador.sv
// Directed bench for loteria_escalonador: basic, round-robin, bad ticket, timeout,
// reset mid-SEND and dropped request; outputs sampled on the falling edge.
module tb_loteria_escalonador;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [79:0] ticket;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [1:0]  prize;
    logic        timeout_err;
    logic        bad_ticket;
    logic [3:0]  chk_num;
    logic        chk_insert;
    logic        chk_finish;
    logic        chk_valid;
    logic [1:0]  chk_prize;
    logic        busy;
    logic [2:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    loteria_escalonador #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ticket      (ticket),
        .gnt         (gnt),
        .done        (done),
        .prize       (prize),
        .timeout_err (timeout_err),
        .bad_ticket  (bad_ticket),
        .chk_num     (chk_num),
        .chk_insert  (chk_insert),
        .chk_finish  (chk_finish),
        .chk_valid   (chk_valid),
        .chk_prize   (chk_prize),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] snap();
        return {gnt, done, prize, timeout_err, bad_ticket, chk_num,
                chk_insert, chk_finish, busy, state};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 9-cycle transaction with an immediate checker answer; terminal drops req on done
    task automatic run_txn(input int g, input logic [19:0] tk, input logic [1:0] pz);
        logic [3:0] dg [5];
        logic [3:0] e_gnt, e_done, e_num;
        logic [1:0] e_prize;
        logic [2:0] e_state;
        logic       e_ins, e_fin, e_busy;
        dg[0] = tk[19:16]; dg[1] = tk[15:12]; dg[2] = tk[11:8];
        dg[3] = tk[7:4];   dg[4] = tk[3:0];
        chk_prize = pz;
        chk_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            e_gnt   = (c <= 8) ? 4'(1 << g) : 4'd0;
            e_done  = (c == 8) ? 4'(1 << g) : 4'd0;
            e_prize = (c == 8) ? pz : 2'd0;
            e_num   = (c <= 5) ? dg[c-1] : 4'd0;
            e_ins   = (c <= 5);
            e_fin   = (c == 6);
            e_busy  = (c <= 8);
            e_state = (c <= 5) ? 3'd1 : (c == 6) ? 3'd2 : (c == 7) ? 3'd3 : (c == 8) ? 3'd4 : 3'd0;
            check($sformatf("txn_g%0d_c%0d", g, c), 32'(snap()),
                  32'({e_gnt, e_done, e_prize, 1'b0, 1'b0, e_num, e_ins, e_fin, e_busy, e_state}));
            if (c == 8) req[g] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;
        reset     = 1'b0;
        req       = '0;
        ticket    = {20'h99999, 20'h00000, 20'h12345, 20'h50967};
        chk_valid = 1'b0;
        chk_prize = '0;

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(snap()), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(snap()), 32'd0);

        // Basic ticket
        req = 4'b0001;
        run_txn(0, 20'h50967, 2'b01);

        // Round-robin from a fresh pointer, terminal 0 re-requests later
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1111;
        run_txn(0, 20'h50967, 2'b10);
        req[0] = 1'b1;
        run_txn(1, 20'h12345, 2'b11);
        run_txn(2, 20'h00000, 2'b00);
        run_txn(3, 20'h99999, 2'b01);
        run_txn(0, 20'h50967, 2'b01);

        // Bad ticket on terminal 2
        ticket[59:40] = 20'h5A967;
        chk_prize = 2'b11;
        chk_valid = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        check("bad_c1", 32'({gnt, done, chk_insert}), 32'({4'b0100, 4'b0000, 1'b0}));
        @(negedge clk);
        check("bad_c2", 32'({gnt, done, bad_ticket, prize, chk_insert}),
              32'({4'b0100, 4'b0100, 1'b1, 2'b00, 1'b0}));
        req = 4'b0000;
        @(negedge clk);
        check("bad_c3", 32'({gnt, done, bad_ticket, busy, state}), 32'd0);

        // Timeout on terminal 1
        chk_valid = 1'b0;
        chk_prize = 2'b11;
        req = 4'b0010;
        done_seen = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (done != 4'd0) done_seen = 1'b1;
            if (c == 7)  check("to_wait_first", 32'({gnt, state}), 32'({4'b0010, 3'd3}));
            if (c == 22) check("to_wait_last", 32'({gnt, state}), 32'({4'b0010, 3'd3}));
        end
        check("to_no_early_done", 32'(done_seen), 32'd0);
        @(negedge clk);
        check("to_reply", 32'({done, timeout_err, prize, gnt}),
              32'({4'b0010, 1'b1, 2'b00, 4'b0010}));
        req = 4'b0000;
        chk_valid = 1'b1;
        @(negedge clk);
        check("to_idle", 32'(snap()), 32'd0);
        chk_valid = 1'b0;
        @(negedge clk);
        check("to_late_valid_ignored", 32'(snap()), 32'd0);

        // Reset during SEND of a terminal-1 transaction
        ticket[59:40] = 20'h00000;
        chk_valid = 1'b1;
        chk_prize = 2'b10;
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check("rst_mid_send_pre", 32'({gnt, chk_insert, chk_num, state}),
              32'({4'b0010, 1'b1, 4'd3, 3'd1}));
        #1 reset = 1'b0;
        #1 check("rst_async_clear", 32'(snap()), 32'd0);
        @(negedge clk);
        check("rst_no_done", 32'(snap()), 32'd0);
        req = 4'b0011;
        reset = 1'b1;
        run_txn(0, 20'h50967, 2'b10);
        req = 4'b0000;
        @(negedge clk);
        check("rst_after_idle", 32'({gnt, state}), 32'd0);

        // Request dropped during WAIT, two WAIT cycles before the answer
        chk_valid = 1'b0;
        chk_prize = 2'b01;
        req = 4'b1000;
        repeat (7) @(negedge clk);
        check("drop_wait1", 32'({gnt, state}), 32'({4'b1000, 3'd3}));
        req = 4'b0000;
        @(negedge clk);
        check("drop_wait2", 32'({gnt, state, done}), 32'({4'b1000, 3'd3, 4'b0000}));
        chk_valid = 1'b1;
        @(negedge clk);
        check("drop_done", 32'({done, prize, gnt, timeout_err}),
              32'({4'b1000, 2'b01, 4'b1000, 1'b0}));
        chk_valid = 1'b0;
        @(negedge clk);
        check("drop_idle", 32'(snap()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/loteria_escalonador.md
# loteria_escalonador

Shared-checker scheduler for the lottery terminal cluster. Up to four ticket terminals request service. The block grants one terminal at a time in round-robin order and latches its 5-digit ticket. It then sequences the single shared checker: five digit inserts, a finish strobe, and a wait for the result. Finally it returns the prize code to the granted terminal with a one-cycle done pulse.

## Interface
- TIMEOUT, 16: maximum WAIT cycles for chk_valid before the transaction is aborted; legal range 1..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  4  per-terminal service request; level, held until that terminal's done.
- ticket  in  80  terminal i ticket at [20i+19:20i]; first digit at [20i+19:20i+16], fifth digit at [20i+3:20i]; BCD.
- gnt  out  4  one-hot grant; high from grant through REPLY.
- done  out  4  one-cycle pulse to the granted terminal.
- prize  out  2  prize code; valid only while done is nonzero, 0 otherwise.
- timeout_err  out  1  pulse with done when the checker did not answer.
- bad_ticket  out  1  pulse with done when the ticket held a digit > 9.
- chk_num  out  4  digit to the checker; 0 when chk_insert is low.
- chk_insert  out  1  digit strobe to the checker.
- chk_finish  out  1  finish strobe to the checker.
- chk_valid  in  1  checker result valid; sampled only in WAIT.
- chk_prize  in  2  checker prize code, qualified by chk_valid.
- busy  out  1  high in any state other than IDLE.
- state  out  3  FSM state for LEDR: IDLE=0, SEND=1, FINISH=2, WAIT=3, REPLY=4.

## Operation
- Reset (reset=0, asynchronous):
  - state=IDLE, round-robin pointer ptr=0, digit index d=0, wait counter=0.
  - All outputs are 0.
- IDLE: when any req bit is high, select the first requester searching from ptr upward and wrapping 3→0. On the next edge:
  - Set gnt[g], latch ticket[g] into a 20-bit register, clear d.
  - If all five digits are ≤ 9, go to SEND.
  - Otherwise set the internal flag bad and go directly to REPLY. The checker is never touched.
- SEND: chk_insert=1, chk_num = latched digit d, first digit first. d increments each cycle. After d=4, go to FINISH. Exactly 5 consecutive insert cycles.
- FINISH: chk_finish=1 for one cycle, clear the wait counter, go to WAIT.
- WAIT:
  - chk_valid=1: capture chk_prize and go to REPLY.
  - Otherwise the counter increments. When chk_valid is still low on the cycle the counter equals TIMEOUT-1, set prize=0, set the internal flag to_err, and go to REPLY.
- REPLY (one cycle):
  - done[g]=1, prize = captured value (0 if bad or to_err).
  - bad_ticket and timeout_err reflect their flags.
  - On exit: ptr = (g+1) mod 4, gnt cleared, flags cleared, go to IDLE.
- gnt is constant for the whole transaction. Changes on req, or on ticket[g], after the grant edge are ignored.
- If a request is dropped mid-service, the transaction still completes and done is still pulsed.
- chk_valid outside WAIT is ignored, including a late response after a timeout.
- Reset mid-transaction aborts immediately. No done pulse is issued, and ptr returns to 0.

## Timing
- Cycle 1 is the cycle after the edge that samples req in IDLE.
- Valid ticket, chk_valid high in the first WAIT cycle:
  - gnt high in cycles 1–8.
  - chk_insert in cycles 1–5.
  - chk_finish in cycle 6.
  - WAIT in cycle 7.
  - done/prize in cycle 8.
  - IDLE in cycle 9.
- Each extra WAIT cycle before chk_valid adds 1 cycle of latency.
- Timeout: exactly TIMEOUT WAIT cycles, then REPLY. done is in cycle 7+TIMEOUT.
- Bad ticket: gnt in cycles 1–2, done in cycle 2.
- Back-to-back transactions: the next grant can occur at the edge that ends the IDLE cycle (cycle 9). There is a minimum of one idle cycle between transactions.
- All outputs are registered. There is no combinational path from req, ticket or chk_* to any output.

## Test plan
- Basic ticket:
  - Stimulus: req=0001, ticket[19:0]=0x50967, checker asserts chk_valid with chk_prize=01 in the first WAIT cycle.
  - Required: chk_num=5,0,9,6,7 in cycles 1–5; chk_finish in cycle 6; done=0001 and prize=01 in cycle 8; no error flags.
- Round-robin:
  - Stimulus: req=1111 held, each terminal dropping req on its own done, checker always answers immediately.
  - Required: grants in the order 0001, 0010, 0100, 1000, one every 9 cycles. A later re-request from terminal 0 is granted after terminal 3.
- Bad ticket:
  - Stimulus: req=0100 with ticket[59:40]=0x5A967.
  - Required: chk_insert never high; done=0100 in cycle 2 with bad_ticket=1 and prize=0.
- Timeout:
  - Stimulus: TIMEOUT=16, chk_valid held low, then pulsed high after REPLY.
  - Required: done in cycle 23 with timeout_err=1 and prize=0. The late chk_valid is ignored and state stays IDLE.
- Reset mid-SEND:
  - Stimulus: assert reset in cycle 3 of a terminal-1 transaction, then release with req=0011.
  - Required: all outputs are 0 immediately on assertion, no done pulse, and terminal 0 is granted first after release.
- Request dropped:
  - Stimulus: deassert req during WAIT.
  - Required: the transaction completes and done is still pulsed to the original terminal.
